// File: rtl/fact_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fact_pkg
// Description : Shared definitions for the factorial control unit, its
//               datapath and the host bus wrapper: state encoding, operand
//               range limits, mux select encodings and the Moore output
//               decode used by the control unit.
// Revision    : 1.0 - initial release
// ============================================================================
package fact_pkg;

  // Default operand width and the largest operand whose factorial fits in
  // 32 bits (12! = 479001600, 13! overflows).
  localparam int N_W_DEFAULT = 4;
  localparam int MAX_N       = 12;

  // Multiplier operand mux (sel1) and register input mux (sel2) encodings.
  localparam logic SEL_ONE  = 1'b0;
  localparam logic SEL_CNT  = 1'b1;
  localparam logic SEL_PROD = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_MULT  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } fact_state_t;

  // Bundle of every strobe the control unit drives.
  typedef struct packed {
    logic sel1;
    logic sel2;
    logic ld_reg;
    logic ld_count;
    logic en_count;
    logic buffer;
    logic busy;
    logic done;
    logic err;
  } fact_ctl_t;

  // Moore output decode: the strobes depend on the state alone.
  function automatic fact_ctl_t decode_state(input fact_state_t s);
    fact_ctl_t c;
    c = '0;
    case (s)
      ST_LOAD: begin
        c.ld_count = 1'b1;
        c.ld_reg   = 1'b1;
        c.sel1     = SEL_ONE;
        c.sel2     = SEL_ONE;
        c.busy     = 1'b1;
      end
      ST_CHECK: begin
        c.busy = 1'b1;
      end
      ST_MULT: begin
        c.sel1     = SEL_CNT;
        c.sel2     = SEL_PROD;
        c.ld_reg   = 1'b1;
        c.en_count = 1'b1;
        c.busy     = 1'b1;
      end
      ST_DONE: begin
        c.buffer = 1'b1;
        c.done   = 1'b1;
      end
      ST_ERR: begin
        c.err = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // True for the states in which a computation is in progress.
  function automatic logic is_busy(input fact_state_t s);
    return (s == ST_LOAD) || (s == ST_CHECK) || (s == ST_MULT);
  endfunction

endpackage : fact_pkg
`default_nettype wire

// File: rtl/fact_cu.sv
`default_nettype none
// ============================================================================
// Module      : fact_cu
// Description : Control unit for the factorial datapath. Range-checks the
//               operand in IDLE, then sequences LOAD -> (CHECK, MULT)* ->
//               DONE with a 4-phase go/done handshake to the host.
//               Optional macro FACT_CYCLE_COUNT_EN adds a saturating
//               16-bit busy-cycle counter on output cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module fact_cu
  import fact_pkg::*;
#(
  parameter int N_W = N_W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           go,
  input  logic [N_W-1:0] factorial,
  input  logic           cnt_gt1,
  output logic           sel1,
  output logic           sel2,
  output logic           ld_reg,
  output logic           ld_count,
  output logic           en_count,
  output logic           buffer,
  output logic           busy,
  output logic           done,
  output logic           err
`ifdef FACT_CYCLE_COUNT_EN
  ,
  output logic [15:0]    cycles
`endif
);

  fact_state_t r_state;
  fact_state_t w_next;
  fact_ctl_t   r_ctl;
  logic        w_over_range;

  // Operand range check; only consulted while in IDLE.
  assign w_over_range = (32'(factorial) > 32'(MAX_N));

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (go) begin
          w_next = w_over_range ? ST_ERR : ST_LOAD;
        end
      end
      ST_LOAD:  w_next = ST_CHECK;
      ST_CHECK: w_next = cnt_gt1 ? ST_MULT : ST_DONE;
      ST_MULT:  w_next = ST_CHECK;
      // Hold the result/error until the host drops go, so a go held high
      // cannot start a second run.
      ST_DONE:  w_next = go ? ST_DONE : ST_IDLE;
      ST_ERR:   w_next = go ? ST_ERR  : ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // State register with outputs registered from the next-state decode, so
  // each output is glitch-free and changes together with the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ctl   <= '0;
    end else begin
      r_state <= w_next;
      r_ctl   <= decode_state(w_next);
    end
  end

  assign sel1     = r_ctl.sel1;
  assign sel2     = r_ctl.sel2;
  assign ld_reg   = r_ctl.ld_reg;
  assign ld_count = r_ctl.ld_count;
  assign en_count = r_ctl.en_count;
  assign buffer   = r_ctl.buffer;
  assign busy     = r_ctl.busy;
  assign done     = r_ctl.done;
  assign err      = r_ctl.err;

`ifdef FACT_CYCLE_COUNT_EN
  logic [15:0] r_cycles;

  // Busy-cycle counter: cleared entering LOAD, counts busy cycles,
  // saturates, and freezes in DONE/ERR/IDLE until the next LOAD.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cycles <= '0;
    end else if (w_next == ST_LOAD) begin
      r_cycles <= '0;
    end else if (is_busy(r_state) && (r_cycles != 16'hFFFF)) begin
      r_cycles <= r_cycles + 16'd1;
    end
  end

  assign cycles = r_cycles;
`endif

  // The counter must never be loaded and decremented on the same edge.
  a_ld_en_excl : assert property (@(posedge clk) disable iff (!rst_n)
    !(ld_count && en_count));

  // A result and an error are never reported together.
  a_done_err_excl : assert property (@(posedge clk) disable iff (!rst_n)
    !(done && err));

endmodule : fact_cu
`default_nettype wire

// File: tb/tb_fact_cu.sv
`default_nettype none
// ============================================================================
// Module      : tb_fact_cu
// Description : Self-checking bench for fact_cu with a behavioural factorial
//               datapath, a table of operand vectors, an expected-result
//               scoreboard queue and hand-written reset / handshake sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fact_cu;
  import fact_pkg::*;

  localparam int N_W = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           go;
  logic [N_W-1:0] factorial;
  logic           cnt_gt1;
  logic           sel1, sel2, ld_reg, ld_count, en_count;
  logic           buffer, busy, done, err;
`ifdef FACT_CYCLE_COUNT_EN
  logic [15:0]    cycles;
`endif

  fact_cu #(.N_W(N_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .go       (go),
    .factorial(factorial),
    .cnt_gt1  (cnt_gt1),
    .sel1     (sel1),
    .sel2     (sel2),
    .ld_reg   (ld_reg),
    .ld_count (ld_count),
    .en_count (en_count),
    .buffer   (buffer),
    .busy     (busy),
    .done     (done),
    .err      (err)
`ifdef FACT_CYCLE_COUNT_EN
    ,
    .cycles   (cycles)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural datapath: down-counter and 32-bit product register.
  logic [N_W-1:0] dp_count = '0;
  logic [31:0]    dp_reg   = 32'd0;
  assign cnt_gt1 = (dp_count > 1);

  always @(posedge clk) begin
    if (ld_count)      dp_count <= factorial;
    else if (en_count) dp_count <= dp_count - 1'b1;
    if (ld_reg)
      dp_reg <= (sel2 == SEL_PROD)
              ? dp_reg * ((sel1 == SEL_CNT) ? 32'(dp_count) : 32'd1)
              : 32'd1;
  end

  // Output vector {sel1,sel2,ld_reg,ld_count,en_count,buffer,busy,done,err}.
  wire [8:0] outs = {sel1, sel2, ld_reg, ld_count, en_count,
                     buffer, busy, done, err};
  localparam logic [8:0] OUTS_IDLE = 9'h000;
  localparam logic [8:0] OUTS_DONE = 9'h00A;
  localparam logic [8:0] OUTS_ERR  = 9'h001;

  typedef struct {
    int          n;
    bit          exp_err;
    int unsigned exp_res;
    int          exp_lat;
    int          exp_mults;
  } vec_t;

  vec_t vecs[8];
  vec_t sb[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one operand, wait for done/err, compare against the scoreboard,
  // hold go for 'hold' extra cycles, then drop it and check IDLE.
  task automatic run_op(input int n, input int hold);
    vec_t e;
    int   cyc, mults;
    bit   strobe, seen_err;
    @(negedge clk);
    factorial = N_W'(n);
    go        = 1'b1;
    cyc = 0; mults = 0; strobe = 1'b0; seen_err = 1'b0;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (en_count) mults++;
      if (ld_reg || ld_count) strobe = 1'b1;
      if (err && !done) seen_err = 1'b1;
    end while (!done && !err && cyc < 64);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    check($sformatf("n=%0d latency", n), cyc, e.exp_lat);
    check($sformatf("n=%0d outs_at_end", n), outs, e.exp_err ? OUTS_ERR : OUTS_DONE);
    if (e.exp_err) begin
      check($sformatf("n=%0d no_strobes", n), strobe, 0);
    end else begin
      check($sformatf("n=%0d result", n), dp_reg, e.exp_res);
      check($sformatf("n=%0d mult_cycles", n), mults, e.exp_mults);
      check($sformatf("n=%0d no_err", n), seen_err, 0);
`ifdef FACT_CYCLE_COUNT_EN
      check($sformatf("n=%0d cycles", n), cycles, e.exp_lat - 1);
`endif
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check($sformatf("n=%0d hold%0d", n, i), outs, e.exp_err ? OUTS_ERR : OUTS_DONE);
    end
    @(negedge clk);
    go = 1'b0;
    @(posedge clk); #1;
    check($sformatf("n=%0d back_to_idle", n), outs, OUTS_IDLE);
  endtask

  initial begin
    vecs[0] = '{n: 0,  exp_err: 0, exp_res: 1,         exp_lat: 3,  exp_mults: 0};
    vecs[1] = '{n: 1,  exp_err: 0, exp_res: 1,         exp_lat: 3,  exp_mults: 0};
    vecs[2] = '{n: 2,  exp_err: 0, exp_res: 2,         exp_lat: 5,  exp_mults: 1};
    vecs[3] = '{n: 5,  exp_err: 0, exp_res: 120,       exp_lat: 11, exp_mults: 4};
    vecs[4] = '{n: 7,  exp_err: 0, exp_res: 5040,      exp_lat: 15, exp_mults: 6};
    vecs[5] = '{n: 12, exp_err: 0, exp_res: 479001600, exp_lat: 25, exp_mults: 11};
    vecs[6] = '{n: 13, exp_err: 1, exp_res: 0,         exp_lat: 1,  exp_mults: 0};
    vecs[7] = '{n: 15, exp_err: 1, exp_res: 0,         exp_lat: 1,  exp_mults: 0};

    // Reset state.
    rst_n = 1'b0; go = 1'b0; factorial = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", outs, OUTS_IDLE);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven operands.
    for (int k = 0; k < 8; k++) begin
      sb.push_back(vecs[k]);
      run_op(vecs[k].n, 1);
    end

    // Synchronous reset in the middle of a multiply, then a fresh run.
    @(negedge clk);
    factorial = N_W'(7);
    go        = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (en_count) break;
    end
    check("reached_mult", en_count, 1);
    @(negedge clk);
    rst_n = 1'b0;
    go    = 1'b0;
    @(posedge clk); #1;
    check("mid_reset_outs", outs, OUTS_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back('{n: 3, exp_err: 0, exp_res: 6, exp_lat: 7, exp_mults: 2});
    run_op(3, 0);

    // go held 5 cycles past done must not restart; then a clean second run.
    sb.push_back('{n: 2, exp_err: 0, exp_res: 2, exp_lat: 5, exp_mults: 1});
    run_op(2, 5);
    sb.push_back('{n: 4, exp_err: 0, exp_res: 24, exp_lat: 9, exp_mults: 3});
    run_op(4, 0);

    check("scoreboard_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fact_cu
`default_nettype wire
